// File: rtl/wrb_arbiter.sv
// wrb_arbiter: shares the single RCU writeback/finish port among the execution
// units (0=ALU, 1=LSU, 2=CSR). Each unit has a small circular FIFO. A
// round-robin arbiter pops one head per cycle into a registered writeback
// stage. A trap flushes every buffered result.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   trapped             flush all FIFOs, drop same-cycle pushes, no grant
//   req_valid/req_ready per-unit handshake (ready depends on FIFO count only)
//   req_prd/data/rob_line/exp/ecause  packed per-unit result fields
//   wrb_done            ROB line finished this cycle
//   wrb_rd_valid        physical register write enable (never for P0/exception)
//   wrb_prd/data/rob_line/exp/ecause  writeback payload
//   wrb_src             index of the unit that produced this writeback
module wrb_arbiter #(
  parameter int unsigned NUM_REQ            = 3,
  parameter int unsigned BUF_DEPTH          = 2,
  parameter int unsigned BUF_CNT_WIDTH      = 2,
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned PHY_REG_ADDR_WIDTH = 6,
  parameter int unsigned ROB_SIZE_WIDTH     = 3,
  parameter int unsigned SRC_WIDTH          = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 trapped,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*PHY_REG_ADDR_WIDTH-1:0] req_prd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
  input  logic [NUM_REQ*ROB_SIZE_WIDTH-1:0]    req_rob_line,
  input  logic [NUM_REQ-1:0]                   req_exp,
  input  logic [NUM_REQ*4-1:0]                 req_ecause,
  output logic                                 wrb_done,
  output logic                                 wrb_rd_valid,
  output logic [PHY_REG_ADDR_WIDTH-1:0]        wrb_prd,
  output logic [DATA_WIDTH-1:0]                wrb_data,
  output logic [ROB_SIZE_WIDTH-1:0]            wrb_rob_line,
  output logic                                 wrb_exp,
  output logic [3:0]                           wrb_ecause,
  output logic [SRC_WIDTH-1:0]                 wrb_src
);

  localparam int unsigned PTR_WIDTH = $clog2(BUF_DEPTH);
  localparam logic [BUF_CNT_WIDTH-1:0] FULL_CNT = BUF_CNT_WIDTH'(BUF_DEPTH);

  logic [PHY_REG_ADDR_WIDTH-1:0] prd_mem    [NUM_REQ][BUF_DEPTH];
  logic [DATA_WIDTH-1:0]         data_mem   [NUM_REQ][BUF_DEPTH];
  logic [ROB_SIZE_WIDTH-1:0]     rob_mem    [NUM_REQ][BUF_DEPTH];
  logic                          exp_mem    [NUM_REQ][BUF_DEPTH];
  logic [3:0]                    ecause_mem [NUM_REQ][BUF_DEPTH];

  logic [PTR_WIDTH-1:0]     wr_ptr  [NUM_REQ];
  logic [PTR_WIDTH-1:0]     rd_ptr  [NUM_REQ];
  logic [BUF_CNT_WIDTH-1:0] cnt     [NUM_REQ];
  logic [BUF_CNT_WIDTH-1:0] cnt_nxt [NUM_REQ];

  logic [NUM_REQ-1:0]   push;
  logic [NUM_REQ-1:0]   pop;
  logic [SRC_WIDTH-1:0] rr_ptr;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic                 grant_any;

  logic [PHY_REG_ADDR_WIDTH-1:0] head_prd;
  logic [DATA_WIDTH-1:0]         head_data;
  logic [ROB_SIZE_WIDTH-1:0]     head_rob_line;
  logic                          head_exp;
  logic [3:0]                    head_ecause;

  // Round-robin search over non-empty FIFOs starting at rr_ptr; idle while trapped.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (!trapped) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        if (!grant_any && (cnt[(32'(rr_ptr) + off) % NUM_REQ] != '0)) begin
          grant_any = 1'b1;
          grant_idx = SRC_WIDTH'((32'(rr_ptr) + off) % NUM_REQ);
        end
      end
    end
  end

  // Per-FIFO push/pop and next occupancy.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_nxt[i] = cnt[i];
      push[i]    = req_valid[i] & req_ready[i] & ~trapped;
      pop[i]     = grant_any & (grant_idx == SRC_WIDTH'(i));
      if (trapped) begin
        cnt_nxt[i] = '0;
      end else if (push[i] && !pop[i]) begin
        cnt_nxt[i] = cnt[i] + BUF_CNT_WIDTH'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_nxt[i] = cnt[i] - BUF_CNT_WIDTH'(1);
      end
    end
  end

  // Head of the granted FIFO.
  always_comb begin
    head_prd      = '0;
    head_data     = '0;
    head_rob_line = '0;
    head_exp      = 1'b0;
    head_ecause   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_WIDTH'(i)) begin
        head_prd      = prd_mem[i][rd_ptr[i]];
        head_data     = data_mem[i][rd_ptr[i]];
        head_rob_line = rob_mem[i][rd_ptr[i]];
        head_exp      = exp_mem[i][rd_ptr[i]];
        head_ecause   = ecause_mem[i][rd_ptr[i]];
      end
    end
  end

  // FIFO storage; contents need no reset, validity is tracked by cnt.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        prd_mem[i][wr_ptr[i]]    <= req_prd[i*PHY_REG_ADDR_WIDTH +: PHY_REG_ADDR_WIDTH];
        data_mem[i][wr_ptr[i]]   <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
        rob_mem[i][wr_ptr[i]]    <= req_rob_line[i*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
        exp_mem[i][wr_ptr[i]]    <= req_exp[i];
        ecause_mem[i][wr_ptr[i]] <= req_ecause[i*4 +: 4];
      end
    end
  end

  // FIFO pointers, counts, ready flags and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      req_ready <= '1;
      rr_ptr    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt[i]       <= cnt_nxt[i];
        req_ready[i] <= (cnt_nxt[i] != FULL_CNT);
        if (trapped) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_WIDTH'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_WIDTH'(1);
        end
      end
      if (grant_any) begin
        rr_ptr <= (grant_idx == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_WIDTH'(1);
      end
    end
  end

  // Registered writeback stage; payload holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrb_done     <= 1'b0;
      wrb_rd_valid <= 1'b0;
      wrb_prd      <= '0;
      wrb_data     <= '0;
      wrb_rob_line <= '0;
      wrb_exp      <= 1'b0;
      wrb_ecause   <= '0;
      wrb_src      <= '0;
    end else begin
      wrb_done     <= grant_any;
      wrb_rd_valid <= grant_any & ~head_exp & (head_prd != '0);
      if (grant_any) begin
        wrb_prd      <= head_prd;
        wrb_data     <= head_data;
        wrb_rob_line <= head_rob_line;
        wrb_exp      <= head_exp;
        wrb_ecause   <= head_ecause;
        wrb_src      <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_wrb_arbiter.sv
// Directed bench for wrb_arbiter: reset, single result, round-robin order,
// backpressure with streaming, exception/P0 handling, trap flush, mid-stream reset.
module tb_wrb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         trapped;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [17:0]  req_prd;
  logic [191:0] req_data;
  logic [8:0]   req_rob_line;
  logic [2:0]   req_exp;
  logic [11:0]  req_ecause;
  logic         wrb_done;
  logic         wrb_rd_valid;
  logic [5:0]   wrb_prd;
  logic [63:0]  wrb_data;
  logic [2:0]   wrb_rob_line;
  logic         wrb_exp;
  logic [3:0]   wrb_ecause;
  logic [1:0]   wrb_src;

  int checks = 0;
  int failures = 0;

  wrb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .trapped      (trapped),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_prd      (req_prd),
    .req_data     (req_data),
    .req_rob_line (req_rob_line),
    .req_exp      (req_exp),
    .req_ecause   (req_ecause),
    .wrb_done     (wrb_done),
    .wrb_rd_valid (wrb_rd_valid),
    .wrb_prd      (wrb_prd),
    .wrb_data     (wrb_data),
    .wrb_rob_line (wrb_rob_line),
    .wrb_exp      (wrb_exp),
    .wrb_ecause   (wrb_ecause),
    .wrb_src      (wrb_src)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    req_prd      = '0;
    req_data     = '0;
    req_rob_line = '0;
    req_exp      = '0;
    req_ecause   = '0;
  endtask

  task automatic set_req(input int i, input logic [5:0] prd, input logic [63:0] data,
                         input logic [2:0] rob, input logic exp, input logic [3:0] ec);
    req_valid[i]           = 1'b1;
    req_prd[i*6 +: 6]      = prd;
    req_data[i*64 +: 64]   = data;
    req_rob_line[i*3 +: 3] = rob;
    req_exp[i]             = exp;
    req_ecause[i*4 +: 4]   = ec;
  endtask

  task automatic do_reset();
    clear_inputs();
    trapped = 1'b0;
    reset   = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    trapped = 1'b0;
    reset   = 1'b1;
    step();
    step();
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", wrb_done); end
    checks++; if (wrb_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", wrb_rd_valid); end
    checks++; if (wrb_data !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", wrb_data); end
    checks++; if (wrb_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", wrb_src); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", req_ready); end
    reset = 1'b0;
    step();
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL post_reset_ready got=%b exp=111", req_ready); end
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL post_reset_done got=%b exp=0", wrb_done); end
  endtask

  task automatic test_single();
    set_req(0, 6'd5, 64'hDEAD, 3'd2, 1'b0, 4'd0);
    step();
    clear_inputs();
    checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req_ready[0]); end
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL single_early_done got=%b exp=0", wrb_done); end
    step();
    checks++; if (wrb_done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", wrb_done); end
    checks++; if (wrb_rd_valid !== 1'b1) begin failures++; $display("FAIL single_rd_valid got=%b exp=1", wrb_rd_valid); end
    checks++; if (wrb_prd !== 6'd5) begin failures++; $display("FAIL single_prd got=%0d exp=5", wrb_prd); end
    checks++; if (wrb_data !== 64'hDEAD) begin failures++; $display("FAIL single_data got=%h exp=dead", wrb_data); end
    checks++; if (wrb_rob_line !== 3'd2) begin failures++; $display("FAIL single_rob got=%0d exp=2", wrb_rob_line); end
    checks++; if (wrb_src !== 2'd0) begin failures++; $display("FAIL single_src got=%0d exp=0", wrb_src); end
    checks++; if (wrb_exp !== 1'b0) begin failures++; $display("FAIL single_exp got=%b exp=0", wrb_exp); end
    step();
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL single_after_done got=%b exp=0", wrb_done); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL single_after_ready got=%b exp=111", req_ready); end
  endtask

  task automatic test_all_three();
    logic [63:0] ed [3] = '{64'hA0, 64'hB1, 64'hC2};
    do_reset();
    set_req(0, 6'd1, 64'hA0, 3'd0, 1'b0, 4'd0);
    set_req(1, 6'd2, 64'hB1, 3'd1, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'hC2, 3'd2, 1'b0, 4'd0);
    step();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (wrb_done !== 1'b1) begin failures++; $display("FAIL rr_done[%0d] got=%b exp=1", k, wrb_done); end
      checks++; if (wrb_src !== 2'(k)) begin failures++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", k, wrb_src, k); end
      checks++; if (wrb_data !== ed[k]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, wrb_data, ed[k]); end
    end
    step();
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL rr_done_end got=%b exp=0", wrb_done); end
    // Pointer wrapped back to 0: unit 0 wins again when all request.
    set_req(0, 6'd1, 64'hA3, 3'd0, 1'b0, 4'd0);
    set_req(1, 6'd2, 64'hB4, 3'd1, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'hC5, 3'd2, 1'b0, 4'd0);
    step();
    clear_inputs();
    step();
    checks++; if (wrb_src !== 2'd0) begin failures++; $display("FAIL rr_wrap_src got=%0d exp=0", wrb_src); end
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int          av [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int          ad [10] = '{'h100, 'h101, 'h102, 'h103, 'h103, 'h104, 'h104, 0, 0, 0};
    int          lv [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int          ld [10] = '{'h200, 'h201, 'h202, 'h202, 0, 0, 0, 0, 0, 0};
    int          edn[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int          es [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    int          edt[10] = '{0, 'h100, 'h200, 'h101, 'h201, 'h102, 'h202, 'h103, 'h104, 0};
    int          er [10] = '{7, 5, 6, 5, 6, 7, 6, 7, 7, 7};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      clear_inputs();
      if (av[k] != 0) set_req(0, 6'd1, 64'(ad[k]), 3'd1, 1'b0, 4'd0);
      if (lv[k] != 0) set_req(1, 6'd2, 64'(ld[k]), 3'd3, 1'b0, 4'd0);
      step();
      checks++; if (req_ready !== 3'(er[k])) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, req_ready, 3'(er[k])); end
      checks++; if (wrb_done !== 1'(edn[k])) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%0d", k, wrb_done, edn[k]); end
      if (edn[k] != 0) begin
        checks++; if (wrb_src !== 2'(es[k])) begin failures++; $display("FAIL b2b_src[%0d] got=%0d exp=%0d", k, wrb_src, es[k]); end
        checks++; if (wrb_data !== 64'(edt[k])) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, wrb_data, edt[k]); end
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_exception();
    clear_inputs();
    set_req(2, 6'd7, 64'h55, 3'd4, 1'b1, 4'd2);
    step();
    clear_inputs();
    step();
    checks++; if (wrb_done !== 1'b1) begin failures++; $display("FAIL exc_done got=%b exp=1", wrb_done); end
    checks++; if (wrb_exp !== 1'b1) begin failures++; $display("FAIL exc_exp got=%b exp=1", wrb_exp); end
    checks++; if (wrb_ecause !== 4'd2) begin failures++; $display("FAIL exc_ecause got=%0d exp=2", wrb_ecause); end
    checks++; if (wrb_rd_valid !== 1'b0) begin failures++; $display("FAIL exc_rd_valid got=%b exp=0", wrb_rd_valid); end
    checks++; if (wrb_src !== 2'd2) begin failures++; $display("FAIL exc_src got=%0d exp=2", wrb_src); end
    checks++; if (wrb_rob_line !== 3'd4) begin failures++; $display("FAIL exc_rob got=%0d exp=4", wrb_rob_line); end
    step();
    set_req(0, 6'd0, 64'h66, 3'd5, 1'b0, 4'd0);
    step();
    clear_inputs();
    step();
    checks++; if (wrb_done !== 1'b1) begin failures++; $display("FAIL p0_done got=%b exp=1", wrb_done); end
    checks++; if (wrb_rd_valid !== 1'b0) begin failures++; $display("FAIL p0_rd_valid got=%b exp=0", wrb_rd_valid); end
    checks++; if (wrb_exp !== 1'b0) begin failures++; $display("FAIL p0_exp got=%b exp=0", wrb_exp); end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 6'd1, 64'hF0, 3'd0, 1'b0, 4'd0);
    set_req(1, 6'd2, 64'hF1, 3'd1, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'hF2, 3'd2, 1'b0, 4'd0);
    step();
    set_req(0, 6'd1, 64'hF3, 3'd0, 1'b0, 4'd0);
    set_req(1, 6'd2, 64'hF4, 3'd1, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'hF5, 3'd2, 1'b0, 4'd0);
    step();
    checks++; if (wrb_data !== 64'hF0 || wrb_done !== 1'b1) begin failures++; $display("FAIL flush_pre got=%h/%b exp=f0/1", wrb_data, wrb_done); end
    // Trap cycle with a fresh ALU push that must be dropped.
    set_req(0, 6'd1, 64'hBAD, 3'd6, 1'b0, 4'd0);
    trapped = 1'b1;
    step();
    trapped = 1'b0;
    clear_inputs();
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", wrb_done); end
    checks++; if (wrb_rd_valid !== 1'b0) begin failures++; $display("FAIL flush_rd_valid got=%b exp=0", wrb_rd_valid); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL flush_ready got=%b exp=111", req_ready); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (wrb_done !== 1'b0 || wrb_rd_valid !== 1'b0) begin failures++; $display("FAIL flush_stale[%0d] got=%b/%b data=%h exp=0/0", k, wrb_done, wrb_rd_valid, wrb_data); end
    end
    // Round-robin pointer survives the flush (it points at unit 1).
    set_req(0, 6'd1, 64'h70, 3'd0, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'h72, 3'd2, 1'b0, 4'd0);
    step();
    clear_inputs();
    step();
    checks++; if (wrb_src !== 2'd2 || wrb_data !== 64'h72) begin failures++; $display("FAIL flush_rr_first got=%0d/%h exp=2/72", wrb_src, wrb_data); end
    step();
    checks++; if (wrb_src !== 2'd0 || wrb_data !== 64'h70) begin failures++; $display("FAIL flush_rr_second got=%0d/%h exp=0/70", wrb_src, wrb_data); end
    step();
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL flush_rr_end got=%b exp=0", wrb_done); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 6'd1, 64'hE0, 3'd0, 1'b0, 4'd0);
    set_req(1, 6'd2, 64'hE1, 3'd1, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'hE2, 3'd2, 1'b0, 4'd0);
    step();
    reset   = 1'b1;
    trapped = 1'b1;
    step();
    checks++; if (wrb_done !== 1'b0 || wrb_rd_valid !== 1'b0 || wrb_exp !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b%b%b exp=000", wrb_done, wrb_rd_valid, wrb_exp); end
    checks++; if (wrb_data !== 64'h0 || wrb_prd !== 6'd0 || wrb_rob_line !== 3'd0) begin failures++; $display("FAIL rmid_payload got=%h/%0d/%0d exp=0/0/0", wrb_data, wrb_prd, wrb_rob_line); end
    checks++; if (wrb_src !== 2'd0 || wrb_ecause !== 4'd0) begin failures++; $display("FAIL rmid_src got=%0d/%0d exp=0/0", wrb_src, wrb_ecause); end
    checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL rmid_ready got=%b exp=111", req_ready); end
    reset   = 1'b0;
    trapped = 1'b0;
    clear_inputs();
    step();
    checks++; if (wrb_done !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", wrb_done); end
    // Pointer was reset to 0: unit 0 wins over unit 2.
    set_req(0, 6'd1, 64'h80, 3'd0, 1'b0, 4'd0);
    set_req(2, 6'd3, 64'h82, 3'd2, 1'b0, 4'd0);
    step();
    clear_inputs();
    step();
    checks++; if (wrb_src !== 2'd0 || wrb_data !== 64'h80) begin failures++; $display("FAIL rmid_ptr0 got=%0d/%h exp=0/80", wrb_src, wrb_data); end
    step();
    checks++; if (wrb_src !== 2'd2 || wrb_data !== 64'h82) begin failures++; $display("FAIL rmid_second got=%0d/%h exp=2/82", wrb_src, wrb_data); end
    step();
    set_req(2, 6'd3, 64'h92, 3'd3, 1'b0, 4'd0);
    step();
    clear_inputs();
    step();
    checks++; if (wrb_done !== 1'b1 || wrb_src !== 2'd2 || wrb_data !== 64'h92) begin failures++; $display("FAIL rmid_csr got=%b/%0d/%h exp=1/2/92", wrb_done, wrb_src, wrb_data); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_back_to_back();
    test_exception();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
